fifo_read_ctrl: RTL and testbench

- Read-side controller for the single-clock FIFO (on_clk_fifo) used in the switch datapath.
- Pops words from the FIFO read port (read/empty/oData) and presents them on a valid/ready stream toward the EDF scheduler/output port logic.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, so sustained throughput is 1 word/cycle with no loss or duplication under arbitrary backpressure.
- Provides flush and a delivered-word counter.

---
 rtl/fifo_read_ctrl.sv | 97 +++++++++
 tb/tb_fifo_read_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for on_clk_fifo: pops FIFO words into a 2-entry skid
// buffer and presents them on a valid/ready stream with flush and word counter.
`timescale 1ns/1ps
module fifo_read_ctrl #(
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 16
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          en,
   input  logic          flush,
   input  logic          f_empty,
   input  logic [DW-1:0] f_data,
   output logic          f_read,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   input  logic          o_ready,
   output logic [CW-1:0] words_out,
   output logic          busy
);

   logic [1:0]    occ_q, occ_d;
   logic          infl_q, infl_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          pop;
   logic          cap;
   logic [2:0]    level;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         occ_q  <= '0;
         infl_q <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= infl_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      pop    = o_valid & o_ready;
      // A word in flight during flush belongs to the discarded stream.
      cap    = infl_q & ~flush;
      level  = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
      f_read = RSTn & en & ~flush & ~f_empty & (level < 3'd2);

      occ_d  = occ_q;
      infl_d = f_read;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;

      if (flush) begin
         occ_d = '0;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, pop};
         unique case ({cap, pop})
            2'b11: begin
               if (occ_q == 2'd2) begin
                  head_d = tail_q;
                  tail_d = f_data;
               end else begin
                  head_d = f_data;
               end
            end
            2'b01: begin
               if (occ_q == 2'd2) head_d = tail_q;
               occ_d = occ_q - 2'd1;
            end
            2'b10: begin
               if (occ_q == 2'd0) head_d = f_data;
               else               tail_d = f_data;
               occ_d = occ_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_valid   = (occ_q != 2'd0);
   assign o_data    = head_q;
   assign words_out = cnt_q;
   assign busy      = (occ_q != 2'd0) | infl_q;

   skid_no_overflow: assert property (@(posedge CLK) disable iff (!RSTn)
      !(cap && !pop && occ_q == 2'd2));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: FIFO model plus an output scoreboard.
`timescale 1ns/1ps
module tb_fifo_read_ctrl;

   logic       CLK;
   logic       RSTn;
   logic       en;
   logic       flush;
   logic       f_empty;
   logic [7:0] f_data;
   logic       f_read;
   logic       o_valid;
   logic [7:0] o_data;
   logic       o_ready;
   logic [3:0] words_out;
   logic       busy;

   fifo_read_ctrl #(.DW(8), .CW(4)) dut (
      .CLK(CLK), .RSTn(RSTn), .en(en), .flush(flush),
      .f_empty(f_empty), .f_data(f_data), .f_read(f_read),
      .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
      .words_out(words_out), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   logic [7:0] fifo[$];
   logic [7:0] exp_q[$];
   int         outstanding = 0;
   int         rd_cnt = 0;
   logic       stalled = 1'b0;
   logic [7:0] held = '0;

   logic       s_valid, s_fread, s_busy;
   logic [7:0] s_data;
   logic [3:0] s_words;

   // One clock: sample at negedge (scoreboard + invariants), then advance the FIFO model.
   task automatic cycle();
      logic       do_rd, do_pop;
      logic [7:0] e;
      @(negedge CLK);
      do_rd   = f_read & ~f_empty;
      do_pop  = o_valid & o_ready;
      s_valid = o_valid; s_data = o_data; s_fread = f_read;
      s_words = words_out; s_busy = busy;
      if (RSTn) begin
         checks++;
         if (f_read && f_empty) begin
            failures++; $display("FAIL read_while_empty f_read=%b f_empty=%b", f_read, f_empty);
         end
         checks++;
         if (f_read && (outstanding - int'(do_pop)) >= 2) begin
            failures++; $display("FAIL read_over_level f_read=%b outstanding=%0d pop=%b required f_read=0", f_read, outstanding, do_pop);
         end
         if (stalled) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== held) begin
               failures++; $display("FAIL stall_hold o_valid=%b o_data=%h required 1/%h", o_valid, o_data, held);
            end
         end
         if (flush) begin
            checks++;
            if (f_read !== 1'b0) begin
               failures++; $display("FAIL flush_read f_read=%b required 0", f_read);
            end
            for (int i = 0; i < outstanding; i++)
               if (exp_q.size() > 0) void'(exp_q.pop_front());
         end else if (do_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL unexpected_word o_data=%h required none", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  failures++; $display("FAIL out_data o_data=%h required %h", o_data, e);
               end
            end
         end
      end
      stalled = RSTn && o_valid && !o_ready && !flush;
      held    = o_data;
      @(posedge CLK);
      if (do_rd && fifo.size() > 0) begin
         f_data <= fifo.pop_front();
         rd_cnt++;
      end
      if (!RSTn || flush) outstanding = 0;
      else outstanding = outstanding + int'(do_rd) - int'(do_pop);
      #1;
      f_empty = (fifo.size() == 0);
   endtask

   task automatic push(input logic [7:0] v);
      fifo.push_back(v);
      exp_q.push_back(v);
      f_empty = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         cycle();
         if (exp_q.size() == 0 && !s_busy && !s_valid) done = 1;
      end
      checks++;
      if (!done) begin
         failures++; $display("FAIL %s_drain_timeout pending=%0d required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      RSTn = 1'b0; en = 1'b1; o_ready = 1'b1;
      fifo.push_back(8'hAA); f_empty = 1'b0;
      #12;
      checks++; if (f_read !== 1'b0)  begin failures++; $display("FAIL reset_f_read got=%b required 0", f_read); end
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b required 0", o_valid); end
      checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_o_data got=%h required 00", o_data); end
      checks++; if (words_out !== 4'h0) begin failures++; $display("FAIL reset_words got=%h required 0", words_out); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b required 0", busy); end
      cycle();
      fifo.delete(); f_empty = 1'b1; en = 1'b0; o_ready = 1'b0;
      RSTn = 1'b1;
   endtask

   task automatic test_stream();
      bit seen = 0;
      for (int v = 1; v <= 8; v++) push(8'(v));
      en = 1'b1; o_ready = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle();
         if (s_fread) seen = 1;
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL stream_first_read_timeout f_read=0 required 1"); end
      cycle();
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL stream_latency1 o_valid=%b required 0", s_valid); end
      for (int k = 1; k <= 8; k++) begin
         cycle();
         checks++;
         if (s_valid !== 1'b1 || s_data !== 8'(k)) begin
            failures++; $display("FAIL stream_word%0d o_valid=%b o_data=%h required 1/%h", k, s_valid, s_data, 8'(k));
         end
      end
      repeat (3) cycle();
      checks++; if (s_words !== 4'd8) begin failures++; $display("FAIL stream_words got=%0d required 8", s_words); end
      checks++; if (s_busy !== 1'b0)  begin failures++; $display("FAIL stream_busy got=%b required 0", s_busy); end
   endtask

   task automatic test_stall();
      do_flush();
      o_ready = 1'b0; en = 1'b1; rd_cnt = 0;
      for (int v = 1; v <= 4; v++) push(8'(v));
      repeat (6) cycle();
      checks++; if (rd_cnt != 2) begin failures++; $display("FAIL stall_reads got=%0d required 2", rd_cnt); end
      checks++; if (fifo.size() != 2) begin failures++; $display("FAIL stall_fifo_left got=%0d required 2", fifo.size()); end
      checks++;
      if (s_valid !== 1'b1 || s_data !== 8'd1) begin
         failures++; $display("FAIL stall_head o_valid=%b o_data=%h required 1/01", s_valid, s_data);
      end
      o_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         checks++;
         if (s_valid !== 1'b1 || s_data !== 8'(k)) begin
            failures++; $display("FAIL stall_resume%0d o_valid=%b o_data=%h required 1/%h", k, s_valid, s_data, 8'(k));
         end
      end
      drain(10, "stall");
      checks++; if (s_words !== 4'd4) begin failures++; $display("FAIL stall_words got=%0d required 4", s_words); end
   endtask

   task automatic test_backpressure();
      int pat[6] = '{1, 0, 0, 1, 0, 1};
      do_flush();
      en = 1'b1;
      for (int v = 1; v <= 8; v++) push(8'(v));
      for (int i = 0; i < 120; i++) begin
         o_ready = (i < 6) ? pat[i][0] : 1'($urandom_range(0, 1));
         cycle();
         if (exp_q.size() == 0 && !s_busy) break;
      end
      o_ready = 1'b1;
      drain(10, "backpressure");
      checks++; if (s_words !== 4'd8) begin failures++; $display("FAIL bp_words got=%0d required 8", s_words); end
   endtask

   task automatic test_empty_refill();
      do_flush();
      en = 1'b1; o_ready = 1'b1;
      push(8'd1);
      repeat (6) cycle();
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL refill_idle_busy got=%b required 0", s_busy); end
      push(8'd5);
      drain(10, "refill");
      checks++; if (s_words !== 4'd2) begin failures++; $display("FAIL refill_words got=%0d required 2", s_words); end
   endtask

   task automatic test_flush();
      do_flush();
      o_ready = 1'b0; en = 1'b1;
      for (int v = 1; v <= 6; v++) push(8'(v));
      repeat (5) cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== 8'd1) begin
         failures++; $display("FAIL flush_pre o_valid=%b o_data=%h required 1/01", s_valid, s_data);
      end
      do_flush();
      cycle();
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b required 0", s_valid); end
      checks++; if (s_words !== 4'd0) begin failures++; $display("FAIL flush_words got=%0d required 0", s_words); end
      o_ready = 1'b1;
      drain(20, "flush_a");
      checks++; if (s_words !== 4'd4) begin failures++; $display("FAIL flush_after_words got=%0d required 4", s_words); end
      // Flush with a read accepted at the preceding edge: word 7 must vanish.
      for (int v = 7; v <= 10; v++) push(8'(v));
      cycle();
      checks++; if (s_fread !== 1'b1) begin failures++; $display("FAIL flush_inflight_read f_read=%b required 1", s_fread); end
      do_flush();
      cycle();
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL flush_b_valid got=%b required 0", s_valid); end
      drain(20, "flush_b");
      checks++; if (s_words !== 4'd3) begin failures++; $display("FAIL flush_b_words got=%0d required 3", s_words); end
   endtask

   task automatic test_wrap();
      bit seen15 = 0, seen0 = 0, done = 0;
      do_flush();
      en = 1'b1; o_ready = 1'b1;
      for (int v = 0; v < 17; v++) push(8'h20 + 8'(v));
      for (int i = 0; i < 40 && !done; i++) begin
         cycle();
         if (s_words == 4'd15) seen15 = 1;
         if (seen15 && s_words == 4'd0) seen0 = 1;
         if (exp_q.size() == 0 && !s_busy && !s_valid) done = 1;
      end
      checks++; if (!done) begin failures++; $display("FAIL wrap_timeout pending=%0d required 0", exp_q.size()); end
      checks++; if (!(seen15 && seen0)) begin failures++; $display("FAIL wrap_seen 15:%0d 0:%0d required 1/1", seen15, seen0); end
      checks++; if (s_words !== 4'd1) begin failures++; $display("FAIL wrap_final got=%0d required 1", s_words); end
   endtask

   task automatic test_async_reset();
      do_flush();
      en = 1'b1; o_ready = 1'b1;
      for (int v = 1; v <= 8; v++) push(8'(v));
      repeat (4) cycle();
      #2;
      RSTn = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0)   begin failures++; $display("FAIL areset_valid got=%b required 0", o_valid); end
      checks++; if (words_out !== 4'h0) begin failures++; $display("FAIL areset_words got=%0d required 0", words_out); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL areset_busy got=%b required 0", busy); end
      checks++; if (f_read !== 1'b0)    begin failures++; $display("FAIL areset_f_read got=%b required 0", f_read); end
      fifo.delete(); exp_q.delete(); f_empty = 1'b1; stalled = 1'b0;
      cycle();
      RSTn = 1'b1;
      push(8'h41);
      drain(10, "areset");
      checks++; if (s_words !== 4'd1) begin failures++; $display("FAIL areset_after_words got=%0d required 1", s_words); end
   endtask

   initial begin
      RSTn = 1'b0; en = 1'b0; flush = 1'b0; o_ready = 1'b0;
      f_empty = 1'b1; f_data = '0;
      test_reset();
      test_stream();
      test_stall();
      test_backpressure();
      test_empty_refill();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
